// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        INIT,
        RUN
    } wb_state_t;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy vector of registers awaiting an MDU result, with three combinational lookups.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 busy_rd
);

    logic [NREG-1:0] busy;

    // Set is applied after clear so a same-index set/clear leaves the bit busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_idx] <= 1'b0;
            if (set_en) busy[set_idx] <= 1'b1;
            busy[REG_ZERO] <= 1'b0;
        end
    end

    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
    assign busy_rd  = busy[rd];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter between WB stage and MDU, with hazard scoreboard.
// Define WB_INIT_SWEEP_EN to zero x1..x31 after reset before entering RUN.
module regfile_wb_ctrl #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32,
    parameter int NREG         = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pipe_we_i,
    input  logic [$clog2(NREG)-1:0]   pipe_rd_i,
    input  logic [XLEN-1:0]           pipe_data_i,
    input  logic                      mdu_valid_i,
    input  logic [$clog2(NREG)-1:0]   mdu_rd_i,
    input  logic [XLEN-1:0]           mdu_data_i,
    output logic                      mdu_ready_o,
    input  logic                      issue_valid_i,
    input  logic [$clog2(NREG)-1:0]   issue_rd_i,
    input  logic [$clog2(NREG)-1:0]   rs1_i,
    input  logic [$clog2(NREG)-1:0]   rs2_i,
    input  logic [$clog2(NREG)-1:0]   id_rd_i,
    output logic                      hazard_o,
    output logic                      pipe_stall_o,
    output logic                      rf_we_o,
    output logic [$clog2(NREG)-1:0]   rf_rd_o,
    output logic [XLEN-1:0]           rf_data_o,
    output logic                      init_done_o
);
    import regfile_pkg::*;

    localparam int IDX_W    = $clog2(NREG);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t           state;
    logic [STARVE_W-1:0] starve;
    logic                in_run;
    logic                take_mdu;
    wb_req_t             wr;
    logic                busy_rs1, busy_rs2, busy_rd;

`ifdef WB_INIT_SWEEP_EN
    logic [IDX_W-1:0] sweep_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= INIT;
            sweep_cnt <= IDX_W'(1);
        end else if (state == INIT) begin
            sweep_cnt <= sweep_cnt + IDX_W'(1);
            if (sweep_cnt == IDX_W'(NREG - 1)) state <= RUN;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        state <= RUN;
    end
`endif

    assign in_run   = (state == RUN);
    assign take_mdu = in_run && mdu_valid_i &&
                      (!pipe_we_i || starve == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve <= '0;
        end else if (!in_run || !mdu_valid_i || take_mdu) begin
            starve <= '0;
        end else if (pipe_we_i && starve != STARVE_W'(STARVE_LIMIT)) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // x0 requests still win arbitration and handshake; only the write is dropped.
    always_comb begin
        wr = '0;
        if (!in_run) begin
`ifdef WB_INIT_SWEEP_EN
            wr.we = 1'b1;
            wr.rd = sweep_cnt;
`endif
        end else if (take_mdu) begin
            wr.we   = (mdu_rd_i != REG_ZERO);
            wr.rd   = mdu_rd_i;
            wr.data = mdu_data_i;
        end else if (pipe_we_i) begin
            wr.we   = (pipe_rd_i != REG_ZERO);
            wr.rd   = pipe_rd_i;
            wr.data = pipe_data_i;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk      (clk_i),
        .rst      (rst_i),
        .set_en   (issue_valid_i && issue_rd_i != REG_ZERO),
        .set_idx  (issue_rd_i),
        .clr_en   (take_mdu),
        .clr_idx  (mdu_rd_i),
        .rs1      (rs1_i),
        .rs2      (rs2_i),
        .rd       (id_rd_i),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

    assign rf_we_o      = wr.we;
    assign rf_rd_o      = wr.rd;
    assign rf_data_o    = wr.data;
    assign mdu_ready_o  = take_mdu;
    assign pipe_stall_o = !in_run || (pipe_we_i && take_mdu);
    assign hazard_o     = !in_run || busy_rs1 || busy_rs2 || busy_rd;
    assign init_done_o  = in_run;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl; sweep checks apply when WB_INIT_SWEEP_EN is defined.
module tb_regfile_wb_ctrl;

    localparam int STARVE_LIMIT = 4;
`ifdef WB_INIT_SWEEP_EN
    localparam int SWEEP_CYCLES = 31;
`else
    localparam int SWEEP_CYCLES = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  rs1_i, rs2_i, id_rd_i;
    logic        hazard_o, pipe_stall_o, rf_we_o, init_done_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: set of registers waiting on the MDU, how many times the
    // current MDU result has been refused, and remaining sweep cycles.
    bit busy_m [32];
    int refused = 0;
    int init_left = 0;

    always #5 clk_i = ~clk_i;

    regfile_wb_ctrl #(.STARVE_LIMIT(STARVE_LIMIT), .XLEN(32), .NREG(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
        .mdu_ready_o(mdu_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .id_rd_i(id_rd_i),
        .hazard_o(hazard_o), .pipe_stall_o(pipe_stall_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
        .init_done_o(init_done_o)
    );

    function automatic bit model_take();
        return (init_left == 0) && mdu_valid_i &&
               (!pipe_we_i || refused >= STARVE_LIMIT);
    endfunction

    function automatic bit model_hazard();
        return (init_left != 0) || busy_m[rs1_i] || busy_m[rs2_i] || busy_m[id_rd_i];
    endfunction

    task automatic idle();
        pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
        mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
        issue_valid_i = 0; issue_rd_i = 0;
        rs1_i = 0; rs2_i = 0; id_rd_i = 0;
    endtask

    // Advance the model by one clock, then the DUT; leaves time at posedge+1.
    task automatic tick();
        bit take;
        bit was_init;
        take = model_take();
        was_init = (init_left != 0);
        if (rst_i) begin
            foreach (busy_m[i]) busy_m[i] = 0;
            refused = 0;
            init_left = SWEEP_CYCLES;
        end else begin
            if (init_left > 0) init_left--;
            if (take) busy_m[mdu_rd_i] = 0;
            if (issue_valid_i && issue_rd_i != 0) busy_m[issue_rd_i] = 1;
            if (was_init || !mdu_valid_i || take) refused = 0;
            else if (pipe_we_i && refused < STARVE_LIMIT) refused++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
        repeat (SWEEP_CYCLES) tick();
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
`ifdef WB_INIT_SWEEP_EN
        for (int k = 1; k <= 31; k++) begin
            mdu_valid_i = 1; mdu_rd_i = 3; mdu_data_i = 32'h1111_2222;
            pipe_we_i = 1; pipe_rd_i = 4; pipe_data_i = 32'h3333_4444;
            @(negedge clk_i);
            vectors++; if (rf_we_o !== 1'b1) begin miscompares++; $display("FAIL sweep_we cycle %0d got %b exp 1", k, rf_we_o); end
            vectors++; if (rf_rd_o !== 5'(k)) begin miscompares++; $display("FAIL sweep_rd cycle %0d got %0d exp %0d", k, rf_rd_o, k); end
            vectors++; if (rf_data_o !== 32'h0) begin miscompares++; $display("FAIL sweep_data cycle %0d got %h exp 0", k, rf_data_o); end
            vectors++; if (mdu_ready_o !== 1'b0) begin miscompares++; $display("FAIL sweep_ready cycle %0d got %b exp 0", k, mdu_ready_o); end
            vectors++; if (pipe_stall_o !== 1'b1 || hazard_o !== 1'b1) begin miscompares++; $display("FAIL sweep_stall_hazard cycle %0d got %b%b exp 11", k, pipe_stall_o, hazard_o); end
            vectors++; if (init_done_o !== 1'b0) begin miscompares++; $display("FAIL sweep_init_done cycle %0d got %b exp 0", k, init_done_o); end
            tick();
        end
        idle();
`endif
        rs1_i = 5'd9;
        @(negedge clk_i);
        vectors++; if (init_done_o !== 1'b1) begin miscompares++; $display("FAIL reset_init_done got %b exp 1", init_done_o); end
        vectors++; if (hazard_o !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %b exp 0", hazard_o); end
        vectors++; if (rf_we_o !== 1'b0 || pipe_stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_idle_outputs got we=%b stall=%b exp 0 0", rf_we_o, pipe_stall_o); end
        tick();
    endtask

    task automatic test_lone_mdu();
        idle();
        issue_valid_i = 1; issue_rd_i = 5;
        tick();
        idle();
        mdu_valid_i = 1; mdu_rd_i = 5; mdu_data_i = 32'hDEADBEEF; rs1_i = 5;
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5) begin miscompares++; $display("FAIL lone_write got we=%b rd=%0d exp 1 5", rf_we_o, rf_rd_o); end
        vectors++; if (rf_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lone_data got %h exp deadbeef", rf_data_o); end
        vectors++; if (mdu_ready_o !== 1'b1 || pipe_stall_o !== 1'b0) begin miscompares++; $display("FAIL lone_handshake got ready=%b stall=%b exp 1 0", mdu_ready_o, pipe_stall_o); end
        vectors++; if (hazard_o !== 1'b1) begin miscompares++; $display("FAIL lone_busy_same_cycle got %b exp 1", hazard_o); end
        tick();
        mdu_valid_i = 0;
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b0) begin miscompares++; $display("FAIL lone_busy_cleared got %b exp 0", hazard_o); end
        tick();
    endtask

    task automatic test_starvation();
        idle();
        mdu_valid_i = 1; mdu_rd_i = 3; mdu_data_i = 32'hA5A5_0003;
        pipe_we_i = 1; pipe_rd_i = 10; pipe_data_i = 32'h0000_1234;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            vectors++; if (mdu_ready_o !== 1'b0 || pipe_stall_o !== 1'b0) begin miscompares++; $display("FAIL starve_pipe_wins cycle %0d got ready=%b stall=%b exp 0 0", c, mdu_ready_o, pipe_stall_o); end
            vectors++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd10 || rf_data_o !== 32'h1234) begin miscompares++; $display("FAIL starve_pipe_write cycle %0d got we=%b rd=%0d data=%h exp 1 10 1234", c, rf_we_o, rf_rd_o, rf_data_o); end
            tick();
        end
        @(negedge clk_i);
        vectors++; if (mdu_ready_o !== 1'b1 || pipe_stall_o !== 1'b1) begin miscompares++; $display("FAIL starve_mdu_forced got ready=%b stall=%b exp 1 1", mdu_ready_o, pipe_stall_o); end
        vectors++; if (rf_rd_o !== 5'd3 || rf_data_o !== 32'hA5A5_0003) begin miscompares++; $display("FAIL starve_mdu_write got rd=%0d data=%h exp 3 a5a50003", rf_rd_o, rf_data_o); end
        tick();
        mdu_rd_i = 6; mdu_data_i = 32'hA5A5_0006;
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk_i);
            vectors++; if (mdu_ready_o !== (c == 10)) begin miscompares++; $display("FAIL starve_restart cycle %0d got ready=%b exp %b", c, mdu_ready_o, (c == 10)); end
            vectors++; if (rf_rd_o !== ((c == 10) ? 5'd6 : 5'd10)) begin miscompares++; $display("FAIL starve_restart_rd cycle %0d got %0d", c, rf_rd_o); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid_i = 1; issue_rd_i = 7;
        tick();
        idle();
        rs2_i = 7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            vectors++; if (hazard_o !== 1'b1) begin miscompares++; $display("FAIL sb_raw_rs2 cycle %0d got %b exp 1", c, hazard_o); end
            tick();
        end
        mdu_valid_i = 1; mdu_rd_i = 7; mdu_data_i = 32'h77;
        issue_valid_i = 1; issue_rd_i = 7;
        @(negedge clk_i);
        vectors++; if (mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL sb_accept_ready got %b exp 1", mdu_ready_o); end
        tick();
        idle();
        id_rd_i = 7;
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins_waw got %b exp 1", hazard_o); end
        mdu_valid_i = 1; mdu_rd_i = 7;
        tick();
        mdu_valid_i = 0;
        issue_valid_i = 1; issue_rd_i = 12; rs1_i = 12;
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b0) begin miscompares++; $display("FAIL sb_cleared got %b exp 0", hazard_o); end
        tick();
        issue_valid_i = 0;
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b1) begin miscompares++; $display("FAIL sb_raw_rs1 got %b exp 1", hazard_o); end
        mdu_valid_i = 1; mdu_rd_i = 12;
        tick();
        idle();
    endtask

    task automatic test_x0();
        idle();
        issue_valid_i = 1; issue_rd_i = 0;
        tick();
        idle();
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b0) begin miscompares++; $display("FAIL x0_issue_hazard got %b exp 0", hazard_o); end
        mdu_valid_i = 1; mdu_rd_i = 0; mdu_data_i = 32'hFFFF_0000;
        #1;
        vectors++; if (mdu_ready_o !== 1'b1 || rf_we_o !== 1'b0 || pipe_stall_o !== 1'b0) begin miscompares++; $display("FAIL x0_mdu got ready=%b we=%b stall=%b exp 1 0 0", mdu_ready_o, rf_we_o, pipe_stall_o); end
        tick();
        idle();
        pipe_we_i = 1; pipe_rd_i = 0; pipe_data_i = 32'h55;
        @(negedge clk_i);
        vectors++; if (rf_we_o !== 1'b0 || pipe_stall_o !== 1'b0) begin miscompares++; $display("FAIL x0_pipe got we=%b stall=%b exp 0 0", rf_we_o, pipe_stall_o); end
        tick();
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        issue_valid_i = 1; issue_rd_i = 9;
        tick();
        idle();
        rst_i = 1;
        tick();
        rst_i = 0;
`ifdef WB_INIT_SWEEP_EN
        repeat (11) tick();
        @(negedge clk_i);
        vectors++; if (rf_rd_o !== 5'd12) begin miscompares++; $display("FAIL midreset_count12 got %0d exp 12", rf_rd_o); end
        rst_i = 1;
        tick();
        rst_i = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                vectors++; if (rf_rd_o !== 5'd1) begin miscompares++; $display("FAIL midreset_restart got %0d exp 1", rf_rd_o); end
            end
            vectors++; if (init_done_o !== (k == 32)) begin miscompares++; $display("FAIL midreset_init_done cycle %0d got %b exp %b", k, init_done_o, (k == 32)); end
            if (k < 32) tick();
        end
`endif
        rs1_i = 9;
        @(negedge clk_i);
        vectors++; if (hazard_o !== 1'b0 || init_done_o !== 1'b1) begin miscompares++; $display("FAIL midreset_busy_clear got hazard=%b done=%b exp 0 1", hazard_o, init_done_o); end
        tick();
        idle();
    endtask

    task automatic test_random();
        bit exp_take, exp_we;
        idle();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            exp_take = model_take();
            exp_we = exp_take ? (mdu_rd_i != 0) : (pipe_we_i && pipe_rd_i != 0);
            vectors++; if (mdu_ready_o !== exp_take) begin miscompares++; $display("FAIL rand_ready n=%0d got %b exp %b", n, mdu_ready_o, exp_take); end
            vectors++; if (pipe_stall_o !== (pipe_we_i && exp_take)) begin miscompares++; $display("FAIL rand_stall n=%0d got %b exp %b", n, pipe_stall_o, pipe_we_i && exp_take); end
            vectors++; if (rf_we_o !== exp_we) begin miscompares++; $display("FAIL rand_we n=%0d got %b exp %b", n, rf_we_o, exp_we); end
            if (exp_we) begin
                vectors++;
                if (rf_rd_o !== (exp_take ? mdu_rd_i : pipe_rd_i) || rf_data_o !== (exp_take ? mdu_data_i : pipe_data_i)) begin
                    miscompares++; $display("FAIL rand_wdata n=%0d got rd=%0d data=%h", n, rf_rd_o, rf_data_o);
                end
            end
            vectors++; if (hazard_o !== model_hazard()) begin miscompares++; $display("FAIL rand_hazard n=%0d got %b exp %b", n, hazard_o, model_hazard()); end
            tick();
            if (!mdu_valid_i || exp_take) begin
                mdu_valid_i = ($urandom_range(0, 2) == 0);
                mdu_rd_i = 5'($urandom_range(0, 7));
                mdu_data_i = $urandom;
            end
            if (!(pipe_we_i && exp_take)) begin
                pipe_we_i = ($urandom_range(0, 3) != 0);
                pipe_rd_i = 5'($urandom_range(0, 31));
                pipe_data_i = $urandom;
            end
            issue_valid_i = ($urandom_range(0, 3) == 0);
            issue_rd_i = 5'($urandom_range(0, 7));
            rs1_i = 5'($urandom_range(0, 15));
            rs2_i = 5'($urandom_range(0, 15));
            id_rd_i = 5'($urandom_range(0, 15));
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_i = 1;
        @(posedge clk_i);
        #1;
        test_reset();
        test_lone_mdu();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_mid_reset();
        do_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
